key_event_unit: RTL and testbench
=================================

# key_event_unit

Converts the level-style 8-bit `keycode` register exported by the USB keyboard subsystem into discrete press, release and typematic-repeat events, buffered in a small FIFO. It sits between `usb_system`'s `keycode_export` and the game/motion logic (ball, later menus), so consumers see one event per key action instead of sampling a static code. Same clock domain as the Nios PIO (50 MHz `Clk`).

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `REPEAT_DELAY`, 25_000_000: idle cycles after press before first repeat (0.5 s).
- `REPEAT_RATE`, 5_000_000: idle cycles between subsequent repeats (0.1 s); both ≥2.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high reset.
- `keycode` in 8: current key from PIO; 8'h00 = no key.
- `ev_valid` out 1: FIFO head valid.
- `ev_ready` in 1: consumer accepts head this cycle.
- `ev_code` out 8: head key code.
- `ev_press` out 1: 1 = press/repeat, 0 = release.
- `ev_repeat` out 1: 1 = typematic repeat.
- `count` out $clog2(DEPTH+1): FIFO occupancy.
- `overflow` out 1: sticky; set when an event is dropped.

## Operation
- Registers: `prev` (last accepted code), latched `old_code`/`new_code`, repeat counter (width $clog2(max(REPEAT_DELAY,REPEAT_RATE))), `phase` bit (0 = awaiting first repeat).
- FSM states: IDLE, PUSH_REL, PUSH_PRS, PUSH_RPT.
- IDLE: if `keycode != prev`: latch old=prev, new=keycode, prev<=keycode; go PUSH_REL if old≠0, else PUSH_PRS if new≠0. Else if prev≠0 and counter reaches threshold−1 (threshold = REPEAT_DELAY if phase=0, else REPEAT_RATE): go PUSH_RPT. Else if prev≠0, counter++.
- PUSH_REL: write {rpt=0, press=0, old}; go PUSH_PRS if new≠0, else IDLE.
- PUSH_PRS: write {0, 1, new}; counter<=0, phase<=0; go IDLE.
- PUSH_RPT: write {1, 1, prev}; counter<=0, phase<=1; go IDLE.
- `keycode` is sampled only in IDLE; changes during PUSH states are compared against updated `prev` on return. Change has priority over repeat in the same cycle.
- Write when FIFO full and no pop this cycle: entry dropped, `overflow`<=1, FSM still advances. Full with simultaneous pop: write accepted, count unchanged.
- FIFO first-word fall-through: `ev_valid = count≠0`; `ev_*` show head combinationally from storage; pop on `ev_valid && ev_ready`. `ev_ready` with empty FIFO ignored.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (synchronous): state IDLE, prev=0, counter=0, phase=0, FIFO empty, `ev_valid`=0, `count`=0, `overflow`=0; `ev_code`/`ev_press`/`ev_repeat` = 0 while empty (storage cleared).
- Reset mid-operation discards queued and in-flight events; a key held through reset produces a fresh press after reset.
- Keycode change seen at edge k: press-only entry written at edge k+1 (`ev_valid` high the cycle after); release+press: release at k+1, press at k+2.
- Held key: first repeat written REPEAT_DELAY+1 edges after press write; subsequent repeats every REPEAT_RATE+1 edges.
- Pop-to-next-head: 0 cycles (next entry visible immediately after pop edge).

## Structure
- Package `key_event_pkg`: `KEY_NONE` = 8'h00, packed struct `key_event_t` {repeat, press, code[7:0]}, FSM enum `kev_state_t`.
- Sub-module `event_fifo`: parameterised synchronous FWFT FIFO of `key_event_t` with push/pop/full/empty/count and drop-on-full flag; FSM and repeat logic stay in `key_event_unit`.

## Test plan
- Reset, keycode 00→04, ev_ready=0 → after 2 edges count=1, head {rpt0, press1, 04}; no further events.
- Keycode 04→1A directly → release 04 then press 1A on consecutive edges; 1A→00 → release 1A only.
- REPEAT_DELAY=8, REPEAT_RATE=4, hold 07 with ev_ready=1 → press, repeat at +9 edges, repeats every 5 edges, ev_repeat=1; release cancels repeats.
- DEPTH=4, ev_ready=0, 5 distinct presses/releases → count=4, overflow=1, first four events retained in order; then push with simultaneous pop when full → accepted, count stays 4.
- Keycode 2C held, Reset pulsed 1 cycle mid-queue → FIFO empty, overflow=0, then press 2C re-issued 2 edges later.
- Keycode toggles 04→05→04 in consecutive cycles during PUSH states → final queue consistent: every press paired with a release, last state press 04.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared types for the keyboard event path: event record, FSM states and
// the empty-slot value used when the event FIFO is cleared.
package key_event_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;

  // 'repeat' is a reserved word, so the typematic flag is named rpt
  typedef struct packed {
    logic       rpt;
    logic       press;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUSH_REL = 2'd1,
    ST_PUSH_PRS = 2'd2,
    ST_PUSH_RPT = 2'd3
  } kev_state_t;

  localparam key_event_t KEV_EMPTY = '{rpt: 1'b0, press: 1'b0, code: KEY_NONE};

  function automatic key_event_t mk_event(input logic rpt, input logic press,
                                          input logic [7:0] code);
    key_event_t ev;
    ev.rpt   = rpt;
    ev.press = press;
    ev.code  = code;
    return ev;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word fall-through FIFO of key events. A push into a full FIFO is
// dropped (sticky overflow) unless a pop frees the slot in the same cycle.
module event_fifo
  import key_event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  key_event_t                   din,
  input  logic                         pop,
  output key_event_t                   dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  key_event_t      mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            overflow_r;
  logic            empty_s;
  logic            full_s;
  logic            pop_s;
  logic            push_s;

  // Qualify requests: pops need data, pushes need room or a same-cycle pop
  always_comb begin
    empty_s = (count_r == {CW{1'b0}});
    full_s  = (count_r == CW'(DEPTH));
    pop_s   = pop && !empty_s;
    push_s  = push && (!full_s || pop_s);
  end

  // Storage, pointers, occupancy and sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= KEV_EMPTY;
      end
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (push && !push_s) begin
        overflow_r <= 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout     = empty_s ? KEV_EMPTY : mem_r[rd_ptr_r];
  assign empty    = empty_s;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/key_event_unit.sv
// Turns the static keycode register into press/release/typematic-repeat
// events and queues them for the game logic.
module key_event_unit
  import key_event_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [7:0]                   keycode,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [7:0]                   ev_code,
  output logic                         ev_press,
  output logic                         ev_repeat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNTW    = $clog2(RPT_MAX);
  localparam logic [CNTW-1:0] DELAY_LAST = CNTW'(REPEAT_DELAY - 1);
  localparam logic [CNTW-1:0] RATE_LAST  = CNTW'(REPEAT_RATE - 1);

  kev_state_t      state_r;
  logic [7:0]      prev_r;
  logic [7:0]      old_r;
  logic [7:0]      new_r;
  logic [CNTW-1:0] cnt_r;
  logic            phase_r;
  logic [CNTW-1:0] thr_last_s;
  logic            push_s;
  key_event_t      ev_in_s;
  key_event_t      head_s;
  logic            empty_s;

  // Event to write this cycle, decoded from the push state
  always_comb begin
    push_s     = 1'b0;
    ev_in_s    = KEV_EMPTY;
    thr_last_s = phase_r ? RATE_LAST : DELAY_LAST;
    case (state_r)
      ST_PUSH_REL: begin
        push_s  = 1'b1;
        ev_in_s = mk_event(1'b0, 1'b0, old_r);
      end
      ST_PUSH_PRS: begin
        push_s  = 1'b1;
        ev_in_s = mk_event(1'b0, 1'b1, new_r);
      end
      ST_PUSH_RPT: begin
        push_s  = 1'b1;
        ev_in_s = mk_event(1'b1, 1'b1, prev_r);
      end
      ST_IDLE: begin
        push_s  = 1'b0;
        ev_in_s = KEV_EMPTY;
      end
      default: begin
        push_s  = 1'b0;
        ev_in_s = KEV_EMPTY;
      end
    endcase
  end

  // Change detection and typematic timer; keycode is only looked at in IDLE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      prev_r  <= KEY_NONE;
      old_r   <= KEY_NONE;
      new_r   <= KEY_NONE;
      cnt_r   <= {CNTW{1'b0}};
      phase_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (keycode != prev_r) begin
            old_r   <= prev_r;
            new_r   <= keycode;
            prev_r  <= keycode;
            state_r <= (prev_r != KEY_NONE) ? ST_PUSH_REL : ST_PUSH_PRS;
          end else if ((prev_r != KEY_NONE) && (cnt_r == thr_last_s)) begin
            state_r <= ST_PUSH_RPT;
          end else if (prev_r != KEY_NONE) begin
            cnt_r <= cnt_r + 1'b1;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_PUSH_REL: begin
          state_r <= (new_r != KEY_NONE) ? ST_PUSH_PRS : ST_IDLE;
        end
        ST_PUSH_PRS: begin
          cnt_r   <= {CNTW{1'b0}};
          phase_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_PUSH_RPT: begin
          cnt_r   <= {CNTW{1'b0}};
          phase_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push     (push_s),
    .din      (ev_in_s),
    .pop      (ev_ready),
    .dout     (head_s),
    .empty    (empty_s),
    .count    (count),
    .overflow (overflow)
  );

  assign ev_valid  = !empty_s;
  assign ev_code   = head_s.code;
  assign ev_press  = head_s.press;
  assign ev_repeat = head_s.rpt;

endmodule

// File: tb/tb_key_event_unit.sv
// Self-checking bench for key_event_unit: directed scenarios plus a random
// key/hold sequence checked against a timestamped event-stream model.
module tb_key_event_unit;
  import key_event_pkg::*;

  localparam int DEPTH = 4;
  localparam int RD    = 8;
  localparam int RR    = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    keycode = 8'h00;
  logic          ev_ready = 1'b0;
  logic          ev_valid;
  logic [7:0]    ev_code;
  logic          ev_press;
  logic          ev_repeat;
  logic [CW-1:0] count;
  logic          overflow;
  key_event_t    head;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  bit mon_en = 1'b0;

  key_event_t got_ev[$];
  int         got_t[$];
  key_event_t exp_ev[$];
  int         exp_t[$];
  logic [7:0] m_cur;
  int         m_next_rpt;

  key_event_unit #(.DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .Clk(clk), .Reset(rst), .keycode(keycode), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_press(ev_press), .ev_repeat(ev_repeat), .count(count),
    .overflow(overflow)
  );

  assign head = {ev_repeat, ev_press, ev_code};

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Record every popped event with the edge number at which it was written
  always @(negedge clk) begin
    if (mon_en && ev_valid && ev_ready) begin
      got_ev.push_back(head);
      got_t.push_back(edge_n);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Drive one key for 'hold' cycles and append what the rules predict:
  // repeats written up to the change edge, then release/press.
  task automatic model_seg(input logic [7:0] nk, input int hold);
    int c;
    int s;
    int p;
    keycode = nk;
    c = edge_n + 1;
    if (nk != m_cur) begin
      s = c;
      if (m_cur != 8'h00) begin
        while (m_next_rpt <= c) begin
          exp_ev.push_back({1'b1, 1'b1, m_cur});
          exp_t.push_back(m_next_rpt);
          if (m_next_rpt == c) s = c + 1;
          m_next_rpt += RR + 1;
        end
        exp_ev.push_back({1'b0, 1'b0, m_cur});
        exp_t.push_back(s + 1);
      end
      if (nk != 8'h00) begin
        p = (m_cur != 8'h00) ? s + 2 : s + 1;
        exp_ev.push_back({1'b0, 1'b1, nk});
        exp_t.push_back(p);
        m_next_rpt = p + RD + 1;
      end
      m_cur = nk;
    end
    repeat (hold) tick();
  endtask

  task automatic start_stream();
    keycode = 8'h00;
    do_reset();
    tick();
    m_cur = 8'h00;
    m_next_rpt = 0;
    got_ev.delete(); got_t.delete(); exp_ev.delete(); exp_t.delete();
    ev_ready = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    keycode = 8'h00;
    tick(); tick();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", ev_valid); end
    total++; if (count !== CW'(0)) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    total++; if (head !== KEV_EMPTY) begin bad++; $display("FAIL reset_head got=%h exp=000", head); end
    rst = 1'b0;
  endtask

  task automatic test_press();
    keycode = 8'h04;
    tick();
    total++; if (count !== CW'(0)) begin bad++; $display("FAIL press_early got=%0d exp=0", count); end
    tick();
    total++; if (count !== CW'(1) || ev_valid !== 1'b1) begin bad++; $display("FAIL press_count got=%0d exp=1", count); end
    total++; if (head !== key_event_t'({1'b0, 1'b1, 8'h04})) begin bad++; $display("FAIL press_head got=%h exp=104", head); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (count !== CW'(1)) begin bad++; $display("FAIL press_quiet got=%0d exp=1", count); end
    end
  endtask

  task automatic test_release_press();
    key_event_t want [3];
    want[0] = {1'b0, 1'b1, 8'h04};
    want[1] = {1'b0, 1'b0, 8'h04};
    want[2] = {1'b0, 1'b1, 8'h1A};
    keycode = 8'h1A;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (count !== CW'(i)) begin bad++; $display("FAIL relprs_count got=%0d exp=%0d", count, i); end
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (head !== want[i]) begin bad++; $display("FAIL relprs_head%0d got=%h exp=%h", i, head, want[i]); end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
    end
    keycode = 8'h00;
    tick();
    total++; if (count !== CW'(0)) begin bad++; $display("FAIL rel_early got=%0d exp=0", count); end
    tick();
    total++; if (head !== key_event_t'({1'b0, 1'b0, 8'h1A}) || count !== CW'(1)) begin
      bad++; $display("FAIL rel_only got=%h/%0d exp=01a/1", head, count);
    end
    repeat (3) tick();
    total++; if (count !== CW'(1)) begin bad++; $display("FAIL rel_quiet got=%0d exp=1", count); end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  task automatic test_repeat();
    start_stream();
    model_seg(8'h07, 40);
    model_seg(8'h00, 12);
    mon_en = 1'b0;
    ev_ready = 1'b0;
    total++; if (got_ev.size() != exp_ev.size()) begin bad++; $display("FAIL rpt_len got=%0d exp=%0d", got_ev.size(), exp_ev.size()); end
    for (int i = 0; i < got_ev.size() && i < exp_ev.size(); i++) begin
      total++; if (got_ev[i] !== exp_ev[i] || got_t[i] != exp_t[i]) begin
        bad++; $display("FAIL rpt_ev%0d got=%h@%0d exp=%h@%0d", i, got_ev[i], got_t[i], exp_ev[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_overflow();
    key_event_t want [4];
    logic [7:0] seq [4];
    want[0] = {1'b0, 1'b0, 8'h04};
    want[1] = {1'b0, 1'b1, 8'h05};
    want[2] = {1'b0, 1'b0, 8'h05};
    want[3] = {1'b0, 1'b0, 8'h06};
    seq[0] = 8'h04; seq[1] = 8'h05; seq[2] = 8'h00; seq[3] = 8'h06;
    keycode = 8'h00;
    ev_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      keycode = seq[i];
      repeat (4) tick();
    end
    total++; if (count !== CW'(4) || overflow !== 1'b1) begin bad++; $display("FAIL ovf_full got=%0d/%0b exp=4/1", count, overflow); end
    total++; if (head !== key_event_t'({1'b0, 1'b1, 8'h04})) begin bad++; $display("FAIL ovf_head got=%h exp=104", head); end
    keycode = 8'h00;
    tick();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    total++; if (count !== CW'(4) || overflow !== 1'b1) begin bad++; $display("FAIL ovf_pushpop got=%0d/%0b exp=4/1", count, overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (head !== want[i]) begin bad++; $display("FAIL ovf_order%0d got=%h exp=%h", i, head, want[i]); end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
    end
    total++; if (count !== CW'(0) || ev_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid();
    keycode = 8'h2C;
    repeat (3) tick();
    total++; if (count !== CW'(1)) begin bad++; $display("FAIL mid_pre got=%0d exp=1", count); end
    do_reset();
    total++; if (count !== CW'(0) || ev_valid !== 1'b0 || overflow !== 1'b0 || head !== KEV_EMPTY) begin
      bad++; $display("FAIL mid_clear got=%0d/%0b/%0b/%h exp=0/0/0/000", count, ev_valid, overflow, head);
    end
    tick();
    total++; if (count !== CW'(0)) begin bad++; $display("FAIL mid_gap got=%0d exp=0", count); end
    tick();
    total++; if (count !== CW'(1) || head !== key_event_t'({1'b0, 1'b1, 8'h2C})) begin
      bad++; $display("FAIL mid_repress got=%0d/%h exp=1/12c", count, head);
    end
  endtask

  task automatic check_pairing(input string name, input logic [7:0] want_key);
    logic [7:0] pressed = 8'h00;
    bit ok = 1'b1;
    foreach (got_ev[i]) begin
      if (got_ev[i].rpt) begin
        if (got_ev[i].code != pressed) ok = 1'b0;
      end else if (got_ev[i].press) begin
        if (pressed != 8'h00) ok = 1'b0;
        pressed = got_ev[i].code;
      end else begin
        if (got_ev[i].code != pressed) ok = 1'b0;
        pressed = 8'h00;
      end
    end
    total++; if (!ok || pressed !== want_key) begin
      bad++; $display("FAIL %s got=%0b/%h exp=1/%h", name, ok, pressed, want_key);
    end
  endtask

  task automatic test_toggle();
    start_stream();
    keycode = 8'h04; tick();
    keycode = 8'h05; tick();
    keycode = 8'h04; tick();
    repeat (6) tick();
    keycode = 8'h05; tick();
    keycode = 8'h04; tick();
    repeat (6) tick();
    check_pairing("toggle_held", 8'h04);
    keycode = 8'h00;
    repeat (6) tick();
    check_pairing("toggle_released", 8'h00);
    mon_en = 1'b0;
    ev_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] keys [5];
    keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h05; keys[3] = 8'h1A; keys[4] = 8'h2C;
    start_stream();
    for (int i = 0; i < 14; i++) begin
      model_seg(keys[$urandom_range(0, 4)], int'($urandom_range(4, 30)));
    end
    model_seg(8'h00, 12);
    mon_en = 1'b0;
    ev_ready = 1'b0;
    total++; if (got_ev.size() != exp_ev.size()) begin bad++; $display("FAIL rand_len got=%0d exp=%0d", got_ev.size(), exp_ev.size()); end
    for (int i = 0; i < got_ev.size() && i < exp_ev.size(); i++) begin
      total++; if (got_ev[i] !== exp_ev[i] || got_t[i] != exp_t[i]) begin
        bad++; $display("FAIL rand_ev%0d got=%h@%0d exp=%h@%0d", i, got_ev[i], got_t[i], exp_ev[i], exp_t[i]);
      end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rand_overflow got=%0b exp=0", overflow); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release_press();
    test_repeat();
    test_overflow();
    test_reset_mid();
    test_toggle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
